// File: rtl/serial_clock_gen_pkg.sv
// Shared definitions for the serial clock generator and the bus-side modules
// that reuse its state encodings and width helper.
package serial_clock_gen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Number of bits needed to hold values 0..value-1 (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_clock_gen_half_period_prescaler.sv
// Half-period prescaler: pulses tick once every CLK_DIV cycles while enabled,
// and clears/holds its count at zero while disabled.
module half_period_prescaler
  import serial_clock_gen_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (clog2(CLK_DIV) < 1) ? 1 : clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge sys_clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/serial_clock_gen.sv
// Burst serial-clock generator: drives N sclk periods at sys_clk/(2*CLK_DIV)
// with single-cycle strobes coincident with each registered sclk transition.
module serial_clock_gen
  import serial_clock_gen_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter bit CPOL      = 1'b0,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_cycles,
  output logic                 sclk,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic                 busy,
  output logic                 done
);

  state_t                 state_q;
  state_t                 state_d;
  logic                   tick;
  logic                   accept;
  logic                   edge_now;
  logic [CNT_WIDTH-1:0]   rem_q;
  logic                   sclk_q;
  logic                   lead_q;
  logic                   trail_q;
  logic                   done_q;

  half_period_prescaler #(
    .CLK_DIV(CLK_DIV)
  ) u_prescaler (
    .sys_clk(sys_clk),
    .rst    (rst),
    .en     (busy),
    .tick   (tick)
  );

  assign accept = (state_q == ST_IDLE) && start;
  // The done cycle is still RUN; with CLK_DIV=1 tick is high there too, so it must not toggle.
  assign edge_now = (state_q == ST_RUN) && !done_q && tick;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start)  state_d = ST_RUN;
      ST_RUN:  if (done_q) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sclk_q  <= CPOL;
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
    end else begin
      lead_q  <= 1'b0;
      trail_q <= 1'b0;
      done_q  <= 1'b0;
      if (state_q == ST_IDLE) begin
        sclk_q <= CPOL;
        if (accept) begin
          rem_q  <= num_cycles;
          // A zero-length burst completes in its single busy cycle.
          done_q <= (num_cycles == '0);
        end
      end else if (edge_now) begin
        sclk_q <= ~sclk_q;
        if (sclk_q == CPOL) begin
          lead_q <= 1'b1;
        end else begin
          trail_q <= 1'b1;
          rem_q   <= (rem_q != '0) ? rem_q - 1'b1 : rem_q;
          done_q  <= (rem_q == CNT_WIDTH'(1));
        end
      end
    end
  end

  assign sclk       = sclk_q;
  assign lead_edge  = lead_q;
  assign trail_edge = trail_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_clock_gen.sv
// Directed and randomised bench for serial_clock_gen over several CPOL/CLK_DIV
// configurations, using a per-cycle expected-output queue.
module tb_serial_clock_gen;

  localparam int NDUT = 5;
  localparam int DIVS [NDUT] = '{2, 4, 1, 3, 7};
  localparam bit POLS [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  logic            sys_clk = 1'b0;
  logic            rst = 1'b1;
  logic [NDUT-1:0] start = '0;
  logic [7:0]      ncyc [NDUT];
  wire  [NDUT-1:0] sclk, lead, trail, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sel = 0;
  int lead_cnt = 0;
  int trail_cnt = 0;
  logic [4:0] exp_q [$];

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    serial_clock_gen #(
      .CLK_DIV  (DIVS[g]),
      .CPOL     (POLS[g]),
      .CNT_WIDTH(8)
    ) u_dut (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .start     (start[g]),
      .num_cycles(ncyc[g]),
      .sclk      (sclk[g]),
      .lead_edge (lead[g]),
      .trail_edge(trail[g]),
      .busy      (busy[g]),
      .done      (done[g])
    );
  end

  // Record layout: {sclk, lead_edge, trail_edge, busy, done}
  function automatic logic [4:0] idle_rec(input int idx);
    return {POLS[idx], 4'b0000};
  endfunction

  task automatic push_burst(input int idx, input int n);
    int d;
    logic p, s, l, t, dn;
    d = DIVS[idx];
    p = POLS[idx];
    if (n == 0) begin
      exp_q.push_back({p, 4'b0011});
    end else begin
      for (int r = 0; r <= 2 * n * d; r++) begin
        s  = (((r / d) % 2) == 1) ? ~p : p;
        l  = ((r % (2 * d)) == d);
        t  = (r > 0) && ((r % (2 * d)) == 0);
        dn = (r == 2 * n * d);
        exp_q.push_back({s, l, t, 1'b1, dn});
      end
    end
  endtask

  task automatic check_now(input string tag);
    logic [4:0] obs, expv;
    if (exp_q.size() > 0) expv = exp_q.pop_front();
    else                  expv = idle_rec(sel);
    obs = {sclk[sel], lead[sel], trail[sel], busy[sel], done[sel]};
    lead_cnt  += int'(obs[3]);
    trail_cnt += int'(obs[2]);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d dut=%0d observed=%b expected=%b", tag, cyc, sel, obs, expv);
    end
  endtask

  task automatic step(input string tag);
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_now(tag);
  endtask

  task automatic check_counts(input string tag, input int n);
    checks++;
    assert (lead_cnt == n && trail_cnt == n) else begin
      errors++;
      $error("FAIL %s_edge_count observed lead=%0d trail=%0d expected=%0d", tag, lead_cnt, trail_cnt, n);
    end
  endtask

  task automatic burst(input int idx, input int n, input int n_after, input string tag);
    int k;
    sel = idx;
    ncyc[idx] = 8'(n);
    start[idx] = 1'b1;
    push_burst(idx, n);
    lead_cnt = 0;
    trail_cnt = 0;
    step(tag);
    start[idx] = 1'b0;
    ncyc[idx] = 8'(n_after);
    k = exp_q.size();
    repeat (k) step(tag);
    repeat (2) step(tag);
    check_counts(tag, n);
  endtask

  initial begin
    int k;
    for (int i = 0; i < NDUT; i++) ncyc[i] = 8'd0;
    rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    for (int i = 0; i < NDUT; i++) begin
      sel = i;
      check_now("reset");
    end
    rst = 1'b0;
    sel = 0;
    step("post_reset");

    // Basic single period, then three periods with inverted polarity.
    burst(0, 1, 1, "t1_cpol0_div2");
    burst(1, 3, 9, "t2_cpol1_div4");

    // Zero-length bursts.
    burst(0, 0, 0, "t3_zero_div2");
    burst(1, 0, 0, "t3_zero_cpol1");

    // Start held high: back-to-back bursts with a one-cycle busy gap.
    sel = 2;
    ncyc[2] = 8'd2;
    start[2] = 1'b1;
    push_burst(2, 2);
    exp_q.push_back(idle_rec(2));
    push_burst(2, 2);
    lead_cnt = 0;
    trail_cnt = 0;
    k = exp_q.size();
    repeat (k) step("t4_hold");
    start[2] = 1'b0;
    repeat (3) step("t4_hold_end");
    check_counts("t4_hold", 4);

    // Reset at the second leading edge of a five-period burst.
    sel = 3;
    ncyc[3] = 8'd5;
    start[3] = 1'b1;
    push_burst(3, 5);
    step("t5_run");
    start[3] = 1'b0;
    repeat (9) step("t5_run");
    rst = 1'b1;
    exp_q.delete();
    step("t5_rst");
    rst = 1'b0;
    repeat (4) step("t5_after_rst");
    burst(3, 1, 1, "t5_restart");

    // Randomised lengths on the CLK_DIV 1/3/7 instances.
    for (int i = 2; i < NDUT; i++) begin
      burst(i, int'($urandom_range(1, 255)), int'($urandom_range(0, 255)), "t6_random");
    end

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_clock_gen.md
Name: serial_clock_gen

Overview:
- Edge generator, the transmit-side counterpart of the edge detector. On request it drives a burst of N serial-clock periods on `sclk` at a programmable division of `sys_clk`.
- Emits single-cycle leading- and trailing-edge strobes aligned to each `sclk` transition, so shift logic in the MITM injection path launches and captures data without re-detecting its own clock.
- Sits between the bus-master state machines and the output pad mux.

Parameters:
- CLK_DIV, 4, half-period of `sclk` in `sys_clk` cycles; legal range ≥1.
- CPOL, 0, idle level of `sclk`; the leading edge is a rise when 0 and a fall when 1.
- CNT_WIDTH, 8, width of `num_cycles` and the internal remaining-period counter.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a burst; sampled only when `busy`=0.
- num_cycles  in  CNT_WIDTH  number of `sclk` periods; latched with `start`.
- sclk  out  1  generated serial clock, registered.
- lead_edge  out  1  pulse in the cycle `sclk` first shows its post-leading-edge level.
- trail_edge  out  1  pulse in the cycle `sclk` returns to CPOL.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Reset values: `sclk`=CPOL; `lead_edge`, `trail_edge`, `busy`, `done` all 0; state IDLE; counters 0.
- States: IDLE, RUN.
- IDLE:
  - `sclk` holds CPOL.
  - If `start`=1 in cycle t0: latch `num_cycles`, clear the half-period counter, go to RUN.
  - `busy`=1 from t0+1.
- RUN:
  - The half-period counter runs 0..CLK_DIV-1. In the cycle after it reaches CLK_DIV-1 it wraps to 0 and `sclk` toggles.
  - The strobe is registered together with `sclk`, so it is coincident with the new level.
  - Edge k (k=1..N):
    - leading edge appears at t0+1+(2k-1)·CLK_DIV with `lead_edge`=1;
    - trailing edge appears at t0+1+2k·CLK_DIV with `trail_edge`=1.
  - The first half-period is an idle lead-in at CPOL level.
  - Each trailing edge decrements the remaining count.
  - On the N-th trailing edge cycle: `done`=1 in that same cycle; `busy`=0 and state IDLE from the next cycle.
- `num_cycles`=0: `busy`=1 for exactly one cycle (t0+1), with `done`=1 in that cycle. No `sclk` toggle, no strobes.
- `start` while `busy`=1, including the `done` cycle: ignored, not queued. The earliest accepted restart is the cycle after `done`.
- `num_cycles` changes after t0 have no effect on the running burst.
- `lead_edge` and `trail_edge` are never 1 in the same cycle. Each is 1 for exactly one cycle per edge.
- CLK_DIV=1: `sclk` = `sys_clk`/2, and strobes alternate every cycle.
- Duty cycle is exactly 50%: both half-periods are CLK_DIV cycles.
- `rst` mid-burst: next cycle `sclk`=CPOL, strobes 0, `busy`=0, no `done`. The burst is abandoned.
- Counter widths:
  - half-period counter = max(1, clog2(CLK_DIV));
  - remaining count = CNT_WIDTH.
  - No wrap is possible: the count stops at 0.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_RUN) and a clog2 constant function, reused by the existing bus-side modules.
- One natural sub-module: `half_period_prescaler`.
  - Inputs: `sys_clk`, `rst`, `en`, where `en` clears and holds the counter at 0 when low.
  - Output: `tick` pulse every CLK_DIV cycles.
- The FSM, `sclk` register and strobes stay in the top.

Test Plan:
1. CPOL=0, CLK_DIV=2, `start` with `num_cycles`=1 at t0=0 → `busy` 1 in cycles 1..5; `sclk` rises at 3 with `lead_edge`, falls at 5 with `trail_edge` and `done`; `busy`=0 at 6.
2. CPOL=1, CLK_DIV=4, `num_cycles`=3 → three periods of 8 cycles. `sclk` idles high, leading edge falls at cycle 5. Exactly 3 `lead_edge` and 3 `trail_edge` pulses; `done` at cycle 25.
3. `num_cycles`=0 → `busy` and `done` both 1 only at t0+1; `sclk` constant CPOL; no strobes.
4. `start` held high continuously with `num_cycles`=2, CLK_DIV=1 → the second burst is accepted the cycle after `done`, and `busy` shows a one-cycle gap. `start` pulses during `busy` create no extra bursts.
5. `rst` asserted at the 2nd leading edge of a 5-period burst → next cycle `sclk`=CPOL, `busy`=0, `done` never pulses; a new `start` then runs normally.
6. Randomised CLK_DIV∈{1,3,7}, `num_cycles`∈{1..255} → the scoreboard checks leading-edge count = trailing-edge count = N and all half-periods equal CLK_DIV.
